// File: rtl/retire_superscalar_pkg.sv
// Shared types and defaults for the superscalar retire stage.
// Contents: sizing constants, memory-size / exception / functional-unit
// enums, the per-slot retire entry, the completion packet, and a helper
// that maps an entry to the status it reports when committed.
package retire_superscalar_pkg;

    localparam int XLEN          = 32;
    localparam int ROB_SZ_DEF    = 32;
    localparam int CO_W_DEF      = 2;
    localparam int RETIRE_W_DEF  = 2;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } MEM_SIZE;

    typedef enum logic [3:0] {
        NO_ERROR      = 4'h0,
        ILLEGAL_INST  = 4'h2,
        HALTED_ON_WFI = 4'hb
    } EXCEPTION_CODE;

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_MULT   = 3'd1,
        FU_LOAD   = 3'd2,
        FU_STORE  = 3'd3,
        FU_BRANCH = 3'd4
    } FUNIT;

    // Everything commit needs to know about one completed instruction.
    typedef struct packed {
        logic            wr_en;
        logic [4:0]      wr_idx;
        logic [XLEN-1:0] result;      // ALU result, or effective address for stores
        logic [XLEN-1:0] npc;
        FUNIT            funit;
        MEM_SIZE         mem_size;
        logic [XLEN-1:0] rs2_value;   // store data
        logic [63:0]     prev_dword;  // memory dword the store merges into
        logic            halt;
        logic            illegal;
    } RETIRE_ENTRY;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rob_index;
        RETIRE_ENTRY entry;
    } CO_RE_PACKET;

    // Illegal takes precedence over halt when both are flagged.
    function automatic EXCEPTION_CODE entry_status(input RETIRE_ENTRY e);
        if (e.illegal)   return ILLEGAL_INST;
        else if (e.halt) return HALTED_ON_WFI;
        else             return NO_ERROR;
    endfunction

endpackage

// File: rtl/retire_superscalar_store_merge.sv
// Combinational store merge: overlays rs2 onto the previous memory dword at
// the byte offset given by addr, according to mem_size.
// Ports: prev_dword/addr/mem_size/rs2 in; dword (merged) and misalign out.
// A misaligned access leaves dword equal to prev_dword.
module retire_superscalar_store_merge
    import retire_superscalar_pkg::*;
(
    input  logic [63:0]     prev_dword,
    input  logic [2:0]      addr,
    input  MEM_SIZE         mem_size,
    input  logic [XLEN-1:0] rs2,
    output logic [63:0]     dword,
    output logic            misalign
);

    always_comb begin
        dword    = prev_dword;
        misalign = 1'b0;
        case (mem_size)
            BYTE: dword[{addr, 3'b000} +: 8] = rs2[7:0];
            HALF: begin
                if (addr[0]) misalign = 1'b1;
                else         dword[{addr[2:1], 4'b0000} +: 16] = rs2[15:0];
            end
            WORD: begin
                if (addr[1:0] != 2'b00) misalign = 1'b1;
                else                    dword[{addr[2], 5'b00000} +: 32] = rs2;
            end
            // A doubleword store cannot be sourced from a 32-bit rs2.
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/retire_superscalar.sv
// N-wide in-order commit stage.
// Buffers out-of-order completions per ROB slot and retires up to RETIRE_W
// consecutive ready slots starting at rob_head each cycle, with same-cycle
// completion bypass. At most one store per cycle goes to the dcache.
// Ports:
//   clock, reset_n          clock and async active-low reset
//   co_packet               CO_W completion packets
//   rob_head                oldest ROB slot
//   flush                   drop all buffered entries, no commit this cycle
//   store_ready             dcache accepts a store this cycle
//   retire_cnt/commit_*     per-lane commit information (thermometer valid)
//   error_status, halted    status of last committed lane; sticky halt
//   store_en/addr/data      merged store issued this cycle
module retire_superscalar
    import retire_superscalar_pkg::*;
#(
    parameter int ROB_SZ   = ROB_SZ_DEF,
    parameter int CO_W     = CO_W_DEF,
    parameter int RETIRE_W = RETIRE_W_DEF
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  CO_RE_PACKET [CO_W-1:0]       co_packet,
    input  logic [$clog2(ROB_SZ)-1:0]    rob_head,
    input  logic                         flush,
    input  logic                         store_ready,
    output logic [$clog2(RETIRE_W+1)-1:0] retire_cnt,
    output logic [RETIRE_W-1:0]          commit_valid,
    output logic [RETIRE_W-1:0]          commit_wr_en,
    output logic [RETIRE_W-1:0][4:0]     commit_wr_idx,
    output logic [RETIRE_W-1:0][XLEN-1:0] commit_wr_data,
    output logic [RETIRE_W-1:0][XLEN-1:0] commit_NPC,
    output EXCEPTION_CODE                error_status,
    output logic                         halted,
    output logic                         store_en,
    output logic [XLEN-1:0]              store_addr,
    output logic [63:0]                  store_data
);

    localparam int IDX_W = $clog2(ROB_SZ);
    localparam int CNT_W = $clog2(RETIRE_W + 1);

    RETIRE_ENTRY            rob_buf [ROB_SZ];
    logic [ROB_SZ-1:0]      valid;
    logic [ROB_SZ-1:0]      commit_mask;
    logic [ROB_SZ-1:0]      write_mask;
    logic [CO_W-1:0]        write_en;

    logic [IDX_W-1:0]       lane_slot  [RETIRE_W];
    logic [RETIRE_W-1:0]    lane_ready;
    RETIRE_ENTRY            lane_entry [RETIRE_W];

    logic                   blocked;
    logic                   halt_commit;
    logic                   store_sel;
    RETIRE_ENTRY            store_entry;
    logic [63:0]            merged;
    logic                   misalign;

    // Lane i looks at slot head+i; a completion for that slot this cycle
    // overrides the buffer (bypass).
    always_comb begin
        for (int i = 0; i < RETIRE_W; i++) begin
            lane_slot[i]  = rob_head + IDX_W'(i);
            lane_ready[i] = valid[lane_slot[i]];
            lane_entry[i] = rob_buf[lane_slot[i]];
            for (int j = 0; j < CO_W; j++) begin
                if (co_packet[j].valid && co_packet[j].rob_index == lane_slot[i]) begin
                    lane_ready[i] = 1'b1;
                    lane_entry[i] = co_packet[j].entry;
                end
            end
        end
    end

    // NOTE: blocking assignments are intentional here: 'blocked' and
    // 'store_sel' carry the in-order decision from one lane to the next
    // within the same evaluation.
    always_comb begin
        retire_cnt     = '0;
        commit_valid   = '0;
        commit_wr_en   = '0;
        commit_wr_idx  = '0;
        commit_wr_data = '0;
        commit_NPC     = '0;
        error_status   = NO_ERROR;
        commit_mask    = '0;
        halt_commit    = 1'b0;
        store_sel      = 1'b0;
        store_entry    = '0;
        blocked        = !reset_n || halted || flush;
        for (int i = 0; i < RETIRE_W; i++) begin
            if (!blocked && lane_ready[i] &&
                !(lane_entry[i].funit == FU_STORE && (!store_ready || store_sel))) begin
                retire_cnt                = CNT_W'(i + 1);
                commit_valid[i]           = 1'b1;
                commit_wr_en[i]           = lane_entry[i].wr_en;
                commit_wr_idx[i]          = lane_entry[i].wr_idx;
                commit_wr_data[i]         = lane_entry[i].result;
                commit_NPC[i]             = lane_entry[i].npc;
                error_status              = entry_status(lane_entry[i]);
                commit_mask[lane_slot[i]] = 1'b1;
                if (lane_entry[i].funit == FU_STORE) begin
                    store_sel   = 1'b1;
                    store_entry = lane_entry[i];
                end
                if (lane_entry[i].halt || lane_entry[i].illegal) begin
                    halt_commit = 1'b1;
                    blocked     = 1'b1;
                end
            end else begin
                blocked = 1'b1;
            end
        end
    end

    // A completion is stored unless flush drops it or it was bypassed
    // straight into a commit this cycle.
    always_comb begin
        write_en   = '0;
        write_mask = '0;
        for (int j = 0; j < CO_W; j++) begin
            if (co_packet[j].valid && !flush && !commit_mask[co_packet[j].rob_index]) begin
                write_en[j]                       = 1'b1;
                write_mask[co_packet[j].rob_index] = 1'b1;
            end
        end
    end

    // NOTE: the entry payload is deliberately not reset; the separate valid
    // vector is what reset clears, so stale payload is never observed.
    always_ff @(posedge clock) begin
        for (int j = 0; j < CO_W; j++) begin
            if (write_en[j]) rob_buf[co_packet[j].rob_index] <= co_packet[j].entry;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid  <= '0;
            halted <= 1'b0;
        end else begin
            valid  <= flush ? '0 : ((valid & ~commit_mask) | write_mask);
            halted <= halted | halt_commit;
        end
    end

    retire_superscalar_store_merge u_store_merge (
        .prev_dword (store_entry.prev_dword),
        .addr       (store_entry.result[2:0]),
        .mem_size   (store_entry.mem_size),
        .rs2        (store_entry.rs2_value),
        .dword      (merged),
        .misalign   (misalign)
    );

    assign store_en   = store_sel && !misalign;
    assign store_addr = store_en ? {store_entry.result[XLEN-1:3], 3'b000} : '0;
    assign store_data = store_en ? merged : '0;

    // Protocol checks on the completion ports and the store path.
    for (genvar j = 0; j < CO_W; j++) begin : g_co_chk
        a_no_overwrite: assert property (@(posedge clock) disable iff (!reset_n)
            (co_packet[j].valid && !flush) |-> !valid[co_packet[j].rob_index]);
        for (genvar k = j + 1; k < CO_W; k++) begin : g_pair
            a_distinct: assert property (@(posedge clock) disable iff (!reset_n)
                (co_packet[j].valid && co_packet[k].valid && !flush)
                |-> (co_packet[j].rob_index != co_packet[k].rob_index));
        end
    end

    a_aligned_store: assert property (@(posedge clock) disable iff (!reset_n)
        store_sel |-> !misalign);

endmodule
